// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory controller.
//   - access length codes for loads and stores
//   - controller FSM state type
//   - width of the wait-cycle counter (covers LATENCY 0..15)
//   - small decode helpers used by dmem_ctrl
package dmem_pkg;

  localparam int LAT_W = 4;

  // Load length codes
  localparam logic [2:0] LEN_LB  = 3'd0;
  localparam logic [2:0] LEN_LH  = 3'd1;
  localparam logic [2:0] LEN_LW  = 3'd2;
  localparam logic [2:0] LEN_LBU = 3'd4;
  localparam logic [2:0] LEN_LHU = 3'd5;

  // Store length codes
  localparam logic [2:0] LEN_SB  = 3'd0;
  localparam logic [2:0] LEN_SH  = 3'd1;
  localparam logic [2:0] LEN_SW  = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Which length codes are meaningful depends on the direction.
  function automatic logic len_legal(input logic we, input logic [2:0] len);
    if (we) return (len == LEN_SB) || (len == LEN_SH) || (len == LEN_SW);
    return (len == LEN_LB) || (len == LEN_LH) || (len == LEN_LW) ||
           (len == LEN_LBU) || (len == LEN_LHU);
  endfunction

  // Low two bits of the code give the size for both loads and stores.
  function automatic logic [3:0] lane_mask(input logic [2:0] len);
    case (len[1:0])
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] len, input logic [1:0] a);
    return ((len[1:0] == 2'd1) && a[0]) || ((len[1:0] == 2'd2) && (a != 2'd0));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: 2^ADDR_W byte storage with four byte lanes.
//   clk    in            write clock
//   addr   in  ADDR_W    byte address of lane 0; lanes 1..3 use addr+1..addr+3 (wrapping)
//   we     in  4         per-lane write enable
//   wdata  in  32        lane i data in bits 8i+7:8i
//   rdata  out 32        combinational read of the four lanes
// Contents are never cleared.
module dmem_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [7:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] lane_addr [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    // Natural ADDR_W-bit overflow gives the wrap at the top of memory.
    assign lane_addr[gi] = addr + ADDR_W'(gi);
    assign rdata[8*gi +: 8] = mem[lane_addr[gi]];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[lane_addr[i]] <= wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-outstanding load/store controller in front of dmem_array.
//   clk, rst (async, active-low)
//   req_valid/req_ready, req_we, req_len, req_addr, req_wdata : request channel
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err                    : response channel
//   busy : high while a request is in flight (WAIT or RESP)
// Parameters: ADDR_W (byte address width), LATENCY (0..15 wait cycles).
// Macro DMEM_MISALIGN_TRAP_EN: misaligned halfword/word accesses fault
// instead of wrapping byte by byte.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_len,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  state_e            state_reg;
  logic [LAT_W-1:0]  cnt_reg;
  logic              we_reg;
  logic [2:0]        len_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic              req_ready_reg, rsp_valid_reg, rsp_err_reg, busy_reg;
  logic [31:0]       rsp_rdata_reg;

  logic              accept, enter_resp, fault, misalign;
  logic              acc_we;
  logic [2:0]        acc_len;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata, mem_rdata, load_data, rdata_next;
  logic [3:0]        mem_we;
  logic              unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_W];

  // req_ready_reg is only ever set in IDLE, so it alone qualifies acceptance.
  assign accept = req_valid & req_ready_reg;

  // With zero latency the array is accessed on the accept edge itself, so the
  // live request fields are used; otherwise the latched copy is used.
  assign enter_resp = (LATENCY == 0) ? accept : ((state_reg == ST_WAIT) && (cnt_reg == '0));
  assign acc_we    = (state_reg == ST_IDLE) ? req_we                : we_reg;
  assign acc_len   = (state_reg == ST_IDLE) ? req_len               : len_reg;
  assign acc_addr  = (state_reg == ST_IDLE) ? req_addr[ADDR_W-1:0]  : addr_reg;
  assign acc_wdata = (state_reg == ST_IDLE) ? req_wdata             : wdata_reg;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = is_misaligned(acc_len, acc_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign fault  = !len_legal(acc_we, acc_len) || misalign;
  assign mem_we = (enter_resp && acc_we && !fault) ? lane_mask(acc_len) : 4'b0000;

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .addr  (acc_addr),
    .we    (mem_we),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

  always_comb begin
    load_data = 32'h0;
    case (acc_len)
      LEN_LB:  load_data = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      LEN_LBU: load_data = {24'h0, mem_rdata[7:0]};
      LEN_LH:  load_data = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      LEN_LHU: load_data = {16'h0, mem_rdata[15:0]};
      LEN_LW:  load_data = mem_rdata;
      default: load_data = 32'h0;
    endcase
  end

  // Stores and faulted requests always answer with zero data.
  assign rdata_next = (fault || acc_we) ? 32'h0 : load_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      we_reg        <= 1'b0;
      len_reg       <= 3'd0;
      addr_reg      <= '0;
      wdata_reg     <= 32'h0;
      req_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 32'h0;
      rsp_err_reg   <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          req_ready_reg <= 1'b1;
          if (accept) begin
            we_reg        <= req_we;
            len_reg       <= req_len;
            addr_reg      <= req_addr[ADDR_W-1:0];
            wdata_reg     <= req_wdata;
            req_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            if (LATENCY == 0) begin
              state_reg     <= ST_RESP;
              rsp_valid_reg <= 1'b1;
              rsp_rdata_reg <= rdata_next;
              rsp_err_reg   <= fault;
            end else begin
              state_reg <= ST_WAIT;
              cnt_reg   <= LAT_W'(LATENCY > 0 ? LATENCY - 1 : 0);
            end
          end
        end
        ST_WAIT: begin
          if (cnt_reg == '0) begin
            state_reg     <= ST_RESP;
            rsp_valid_reg <= 1'b1;
            rsp_rdata_reg <= rdata_next;
            rsp_err_reg   <= fault;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_RESP: begin
          // rsp_rdata/rsp_err are left untouched so they hold while waiting.
          if (rsp_ready) begin
            state_reg     <= ST_IDLE;
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            req_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          rsp_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          req_ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: self-checking bench for dmem_ctrl. Three instances with
// LATENCY 1, 3 and 0 share a clock; each has its own reset and request/
// response signals. Directed vectors run on the LATENCY=1 instance, a
// reset-abort sequence on LATENCY=3, then randomized traffic on all three
// against a byte-array reference model.
module tb_dmem_ctrl;

  localparam int NI = 3;

  logic        clk;
  logic        rst       [NI];
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_we    [NI];
  logic [2:0]  req_len   [NI];
  logic [31:0] req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic        rsp_valid [NI];
  logic        rsp_ready [NI];
  logic [31:0] rsp_rdata [NI];
  logic        rsp_err   [NI];
  logic        busy      [NI];

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mdl [NI][256];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    dmem_ctrl #(
      .ADDR_W  (8),
      .LATENCY (gi == 0 ? 1 : (gi == 1 ? 3 : 0))
    ) u_dut (
      .clk       (clk),
      .rst       (rst[gi]),
      .req_valid (req_valid[gi]),
      .req_ready (req_ready[gi]),
      .req_we    (req_we[gi]),
      .req_len   (req_len[gi]),
      .req_addr  (req_addr[gi]),
      .req_wdata (req_wdata[gi]),
      .rsp_valid (rsp_valid[gi]),
      .rsp_ready (rsp_ready[gi]),
      .rsp_rdata (rsp_rdata[gi]),
      .rsp_err   (rsp_err[gi]),
      .busy      (busy[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int idx);
    return (idx == 0) ? 1 : ((idx == 1) ? 3 : 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference model: sizes and sign rules computed arithmetically from the
  // length code; memory is a plain byte array with modulo-256 addressing.
  task automatic model_txn(input int idx, input logic we, input logic [2:0] len,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] exp_rdata, output logic exp_err);
    int a, size;
    bit legal, sgn, mis;
    longint val;
    a = int'(addr % 256);
    size = (len == 0 || len == 4) ? 1 : ((len == 1 || len == 5) ? 2 : 4);
    legal = we ? (len <= 2) : (len <= 2 || len == 4 || len == 5);
    sgn = (len == 0 || len == 1);
    mis = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = (a % size) != 0;
`endif
    exp_rdata = 32'h0;
    exp_err   = 1'b0;
    if (!legal || mis) begin
      exp_err = 1'b1;
    end else if (we) begin
      for (int i = 0; i < size; i++) mdl[idx][(a + i) % 256] = 8'((wdata >> (8 * i)) & 32'hff);
    end else begin
      val = 0;
      for (int i = 0; i < size; i++) val = val + (longint'(mdl[idx][(a + i) % 256]) << (8 * i));
      if (sgn && size < 4 && val >= (64'sd1 <<< (8 * size - 1))) val = val - (64'sd1 <<< (8 * size));
      exp_rdata = 32'(val);
    end
  endtask

  // One complete request/response exchange. hold = cycles rsp_ready stays low
  // after rsp_valid is seen; stability is checked throughout.
  task automatic run_txn(input int idx, input logic we, input logic [2:0] len,
                         input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                         output logic [31:0] rdata, output logic err);
    int n, lat;
    bit stable;
    rdata = 32'h0;
    err = 1'b0;
    @(negedge clk);
    req_valid[idx] = 1'b1;
    req_we[idx]    = we;
    req_len[idx]   = len;
    req_addr[idx]  = addr;
    req_wdata[idx] = wdata;
    n = 0;
    while (req_ready[idx] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check("req_ready_timeout", 32'(req_ready[idx]), 32'h1);
      req_valid[idx] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[idx] = 1'b0;
    lat = 1;
    if (lat_of(idx) > 0) check("busy_in_wait", 32'(busy[idx]), 32'h1);
    while (rsp_valid[idx] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_latency", 32'(lat), 32'(lat_of(idx) + 1));
    check("busy_in_resp", 32'(busy[idx]), 32'h1);
    check("req_ready_in_resp", 32'(req_ready[idx]), 32'h0);
    rdata = rsp_rdata[idx];
    err   = rsp_err[idx];
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (rsp_valid[idx] !== 1'b1 || rsp_rdata[idx] !== rdata ||
          rsp_err[idx] !== err || req_ready[idx] !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) check("hold_stable", 32'(stable), 32'h1);
    rsp_ready[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[idx] = 1'b0;
    check("rsp_valid_after_release", 32'(rsp_valid[idx]), 32'h0);
    check("req_ready_after_release", 32'(req_ready[idx]), 32'h1);
    check("busy_after_release", 32'(busy[idx]), 32'h0);
    $display("txn i%0d we=%0d len=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             idx, we, len, addr, wdata, rdata, err, lat);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic we, input logic [2:0] len, input logic [31:0] addr,
                              input logic [31:0] wdata, input int hold,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.len = len; v.addr = addr; v.wdata = wdata;
    v.hold = hold; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  initial begin
    logic [31:0] rd, exp_rd;
    logic er, exp_er;

    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_len[i] = 3'd0;
      req_addr[i] = 32'h0; req_wdata[i] = 32'h0; rsp_ready[i] = 1'b0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("rst_req_ready", 32'(req_ready[i]), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid[i]), 32'h0);
      check("rst_rsp_rdata", rsp_rdata[i], 32'h0);
      check("rst_rsp_err", 32'(rsp_err[i]), 32'h0);
      check("rst_busy", 32'(busy[i]), 32'h0);
      rst[i] = 1'b1;
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) check("post_rst_req_ready", 32'(req_ready[i]), 32'h1);

    // Directed vectors on the LATENCY=1 instance
    tbl.push_back(mk(1, 3'd2, 32'h10,       32'h8badf00d, 0, 32'h0,        0));
    tbl.push_back(mk(0, 3'd2, 32'h10,       32'h0,        5, 32'h8badf00d, 0));
    tbl.push_back(mk(0, 3'd2, 32'hffffff10, 32'h0,        0, 32'h8badf00d, 0));
    tbl.push_back(mk(1, 3'd2, 32'h00,       32'h03020100, 0, 32'h0,        0));
    tbl.push_back(mk(1, 3'd2, 32'h04,       32'h00000000, 0, 32'h0,        0));
    tbl.push_back(mk(1, 3'd0, 32'h04,       32'h12345680, 0, 32'h0,        0));
    tbl.push_back(mk(0, 3'd0, 32'h04,       32'h0,        0, 32'hffffff80, 0));
    tbl.push_back(mk(0, 3'd4, 32'h04,       32'h0,        0, 32'h00000080, 0));
    tbl.push_back(mk(1, 3'd1, 32'h06,       32'habcd8001, 0, 32'h0,        0));
    tbl.push_back(mk(0, 3'd1, 32'h06,       32'h0,        0, 32'hffff8001, 0));
    tbl.push_back(mk(0, 3'd5, 32'h06,       32'h0,        0, 32'h00008001, 0));
    tbl.push_back(mk(0, 3'd2, 32'h04,       32'h0,        0, 32'h80010080, 0));
    tbl.push_back(mk(1, 3'd2, 32'h20,       32'h11223344, 0, 32'h0,        0));
    tbl.push_back(mk(1, 3'd0, 32'h21,       32'h000000aa, 0, 32'h0,        0));
    tbl.push_back(mk(0, 3'd2, 32'h20,       32'h0,        0, 32'h1122aa44, 0));
    tbl.push_back(mk(0, 3'd3, 32'h20,       32'h0,        0, 32'h0,        1));
    tbl.push_back(mk(0, 3'd6, 32'h20,       32'h0,        0, 32'h0,        1));
    tbl.push_back(mk(1, 3'd4, 32'h20,       32'hffffffff, 0, 32'h0,        1));
    tbl.push_back(mk(1, 3'd7, 32'h20,       32'hffffffff, 0, 32'h0,        1));
    tbl.push_back(mk(0, 3'd2, 32'h20,       32'h0,        2, 32'h1122aa44, 0));
    tbl.push_back(mk(0, 3'd0, 32'h23,       32'h0,        0, 32'h00000011, 0));
    tbl.push_back(mk(0, 3'd1, 32'h22,       32'h0,        0, 32'h00001122, 0));
`ifdef DMEM_MISALIGN_TRAP_EN
    tbl.push_back(mk(0, 3'd2, 32'h13,       32'h0,        0, 32'h0,        1));
    tbl.push_back(mk(0, 3'd1, 32'h05,       32'h0,        0, 32'h0,        1));
    tbl.push_back(mk(1, 3'd2, 32'h02,       32'hdeadbeef, 0, 32'h0,        1));
    tbl.push_back(mk(1, 3'd1, 32'h01,       32'hdeadbeef, 0, 32'h0,        1));
    tbl.push_back(mk(0, 3'd2, 32'h00,       32'h0,        0, 32'h03020100, 0));
    tbl.push_back(mk(0, 3'd2, 32'h04,       32'h0,        0, 32'h80010080, 0));
`else
    tbl.push_back(mk(1, 3'd2, 32'hfe,       32'h44332211, 0, 32'h0,        0));
    tbl.push_back(mk(0, 3'd4, 32'hfe,       32'h0,        0, 32'h00000011, 0));
    tbl.push_back(mk(0, 3'd4, 32'hff,       32'h0,        0, 32'h00000022, 0));
    tbl.push_back(mk(0, 3'd4, 32'h00,       32'h0,        0, 32'h00000033, 0));
    tbl.push_back(mk(0, 3'd4, 32'h01,       32'h0,        0, 32'h00000044, 0));
    tbl.push_back(mk(0, 3'd2, 32'hfe,       32'h0,        0, 32'h44332211, 0));
    tbl.push_back(mk(0, 3'd2, 32'h02,       32'h0,        0, 32'h00800302, 0));
    tbl.push_back(mk(0, 3'd1, 32'hff,       32'h0,        0, 32'h00003322, 0));
`endif
    foreach (tbl[k]) begin
      run_txn(0, tbl[k].we, tbl[k].len, tbl[k].addr, tbl[k].wdata, tbl[k].hold, rd, er);
      check($sformatf("vec%0d_rdata", k), rd, tbl[k].exp_rdata);
      check($sformatf("vec%0d_err", k), 32'(er), 32'(tbl[k].exp_err));
    end

    // Reset during WAIT aborts a pending store (LATENCY=3 instance)
    run_txn(1, 1'b1, 3'd2, 32'h40, 32'h5a5a5a5a, 0, rd, er);
    check("abort_setup_err", 32'(er), 32'h0);
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_len[1] = 3'd2;
    req_addr[1] = 32'h40; req_wdata[1] = 32'hdeadbeef;
    check("abort_req_ready", 32'(req_ready[1]), 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    check("abort_busy_wait", 32'(busy[1]), 32'h1);
    rst[1] = 1'b0;
    #1;
    check("abort_rsp_valid", 32'(rsp_valid[1]), 32'h0);
    check("abort_req_ready_low", 32'(req_ready[1]), 32'h0);
    check("abort_busy", 32'(busy[1]), 32'h0);
    repeat (3) @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    check("abort_idle_ready", 32'(req_ready[1]), 32'h1);
    check("abort_idle_valid", 32'(rsp_valid[1]), 32'h0);
    run_txn(1, 1'b0, 3'd2, 32'h40, 32'h0, 0, rd, er);
    check("abort_prior_contents", rd, 32'h5a5a5a5a);
    $display("txn i1 reset-abort sequence done");

    // Randomized traffic against the reference model
    for (int i = 0; i < NI; i++) begin
      for (int a = 0; a < 256; a += 4) begin
        logic [31:0] w;
        w = $urandom;
        model_txn(i, 1'b1, 3'd2, 32'(a), w, exp_rd, exp_er);
        run_txn(i, 1'b1, 3'd2, 32'(a), w, 0, rd, er);
        check("init_rdata", rd, exp_rd);
        check("init_err", 32'(er), 32'(exp_er));
      end
      for (int t = 0; t < 60; t++) begin
        logic we;
        logic [2:0] len;
        logic [31:0] addr, wdata;
        we    = 1'($urandom_range(0, 1));
        len   = 3'($urandom_range(0, 7));
        addr  = $urandom;
        wdata = $urandom;
        model_txn(i, we, len, addr, wdata, exp_rd, exp_er);
        run_txn(i, we, len, addr, wdata, int'($urandom_range(0, 2)), rd, er);
        check("rand_rdata", rd, exp_rd);
        check("rand_err", 32'(er), 32'(exp_er));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
